// File: rtl/hdmi_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C register-transaction engine between N_REQ requesters,
// with an optional per-requester lock for atomic read-modify-write and an engine watchdog.
module hdmi_i2c_arbiter #(
    parameter int N_REQ        = 2,
    parameter int TIMEOUT      = 4096,
    parameter int LOCK_TIMEOUT = 64,
    localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_rw,
    input  logic [8*N_REQ-1:0] req_reg,
    input  logic [8*N_REQ-1:0] req_wdata,
    input  logic [N_REQ-1:0]   req_lock,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_rdata,
    output logic               rsp_err,
    output logic               eng_start,
    output logic               eng_abort,
    output logic               eng_rw,
    output logic [7:0]         eng_reg,
    output logic [7:0]         eng_wdata,
    input  logic               eng_done,
    input  logic               eng_nack,
    input  logic [7:0]         eng_rdata,
    output logic               busy,
    output logic [IW-1:0]      grant_idx
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int LW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

    // Handshake: a requester holds req[i] (and its req_* fields) high until it sees its
    // one-cycle rsp_valid[i]; rsp_rdata/rsp_err are valid in that same cycle.
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_HOLD} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  last_grant_q, last_grant_d, lock_owner_q, lock_owner_d, grant_d, pick;
    logic           locked_q, locked_d, lock_req_q, lock_req_d, found;
    logic [TW-1:0]  timer_q, timer_d;
    logic [LW-1:0]  lock_ctr_q, lock_ctr_d;
    logic [N_REQ-1:0] eligible, rsp_valid_d;
    logic           eng_start_d, eng_abort_d, eng_rw_d, rsp_err_d;
    logic [7:0]     eng_reg_d, eng_wdata_d, rsp_rdata_d;

    // Round-robin pick starting one past the last winner; a held lock narrows the field.
    always_comb begin
        eligible = req;
        if (locked_q) begin
            eligible = '0;
            eligible[lock_owner_q] = req[lock_owner_q];
        end
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && eligible[(int'(last_grant_q) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = IW'((int'(last_grant_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_owner_d = lock_owner_q;
        locked_d     = locked_q;
        lock_req_d   = lock_req_q;
        lock_ctr_d   = lock_ctr_q;
        timer_d      = timer_q;
        grant_d      = grant_idx;
        eng_rw_d     = eng_rw;
        eng_reg_d    = eng_reg;
        eng_wdata_d  = eng_wdata;
        rsp_err_d    = rsp_err;
        rsp_rdata_d  = rsp_rdata;
        eng_start_d  = 1'b0;
        eng_abort_d  = 1'b0;
        rsp_valid_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (locked_q && !req[lock_owner_q]) begin
                    if (lock_ctr_q == LW'(LOCK_TIMEOUT - 1)) begin
                        locked_d   = 1'b0;
                        lock_ctr_d = '0;
                    end else begin
                        lock_ctr_d = lock_ctr_q + 1'b1;
                    end
                end else if (found) begin
                    eng_rw_d    = req_rw[pick];
                    eng_reg_d   = req_reg[8*pick +: 8];
                    eng_wdata_d = req_wdata[8*pick +: 8];
                    lock_req_d  = req_lock[pick];
                    grant_d     = pick;
                    lock_ctr_d  = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start_d = 1'b1;
                timer_d     = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the timeout cycle is still honoured; no abort then.
                if (eng_done) begin
                    rsp_err_d   = eng_nack;
                    rsp_rdata_d = eng_rw ? eng_rdata : 8'h00;
                    state_d     = S_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    eng_abort_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 8'h00;
                    state_d     = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid_d[grant_idx] = 1'b1;
                last_grant_d = grant_idx;
                if (lock_req_q && !rsp_err) begin
                    locked_d     = 1'b1;
                    lock_owner_d = grant_idx;
                    lock_ctr_d   = '0;
                end else begin
                    locked_d = 1'b0;
                end
                state_d = S_HOLD;
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            last_grant_q <= IW'(N_REQ - 1);
            lock_owner_q <= '0;
            locked_q     <= 1'b0;
            lock_req_q   <= 1'b0;
            lock_ctr_q   <= '0;
            timer_q      <= '0;
            grant_idx    <= '0;
            eng_start    <= 1'b0;
            eng_abort    <= 1'b0;
            eng_rw       <= 1'b0;
            eng_reg      <= 8'h00;
            eng_wdata    <= 8'h00;
            rsp_valid    <= '0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= 8'h00;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_owner_q <= lock_owner_d;
            locked_q     <= locked_d;
            lock_req_q   <= lock_req_d;
            lock_ctr_q   <= lock_ctr_d;
            timer_q      <= timer_d;
            grant_idx    <= grant_d;
            eng_start    <= eng_start_d;
            eng_abort    <= eng_abort_d;
            eng_rw       <= eng_rw_d;
            eng_reg      <= eng_reg_d;
            eng_wdata    <= eng_wdata_d;
            rsp_valid    <= rsp_valid_d;
            rsp_err      <= rsp_err_d;
            rsp_rdata    <= rsp_rdata_d;
            busy         <= (state_d != S_IDLE);
        end
    end
endmodule

// File: tb/tb_hdmi_i2c_arbiter.sv
// Directed bench for hdmi_i2c_arbiter: engine responder tasks drive the DUT, and every
// response is checked against an expected queue of {winner, err, rdata}.
module tb_hdmi_i2c_arbiter;
    localparam int N_REQ        = 2;
    localparam int TIMEOUT      = 4096;
    localparam int LOCK_TIMEOUT = 64;
    localparam int IW           = 1;
    localparam int W            = 12;

    logic               clk, resetn;
    logic [N_REQ-1:0]   req, req_rw, req_lock, rsp_valid;
    logic [8*N_REQ-1:0] req_reg, req_wdata;
    logic [7:0]         rsp_rdata, eng_reg, eng_wdata, eng_rdata;
    logic               rsp_err, eng_start, eng_abort, eng_rw, eng_done, eng_nack, busy;
    logic [IW-1:0]      grant_idx;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int abort_cnt = 0;

    hdmi_i2c_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_rw(req_rw), .req_reg(req_reg),
        .req_wdata(req_wdata), .req_lock(req_lock), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .eng_start(eng_start),
        .eng_abort(eng_abort), .eng_rw(eng_rw), .eng_reg(eng_reg), .eng_wdata(eng_wdata),
        .eng_done(eng_done), .eng_nack(eng_nack), .eng_rdata(eng_rdata), .busy(busy),
        .grant_idx(grant_idx)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] enc(input logic [N_REQ-1:0] v);
        enc = '0;
        for (int i = 0; i < N_REQ; i++) if (v[i]) enc = 3'(i);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_exp(input int idx, input logic err, input logic [7:0] rd);
        exp_q.push_back({3'(idx), err, rd});
    endtask

    // Driver tasks
    task automatic raise(input int i, input logic rw, input logic [7:0] ra,
                         input logic [7:0] wd, input logic lk);
        req_rw[i]           = rw;
        req_reg[8*i +: 8]   = ra;
        req_wdata[8*i +: 8] = wd;
        req_lock[i]         = lk;
        req[i]              = 1'b1;
    endtask

    task automatic serve(input int idx, input logic [7:0] ra, input logic [7:0] wd,
                         input int lat, input logic nack, input logic [7:0] rd);
        int n = 0;
        while (eng_start !== 1'b1 && n < 200) begin tick(); n++; end
        check("start_seen", 32'(eng_start), 32'd1);
        check("grant_idx", 32'(grant_idx), 32'(idx));
        check("eng_reg", 32'(eng_reg), 32'(ra));
        check("eng_wdata", 32'(eng_wdata), 32'(wd));
        check("busy_op", 32'(busy), 32'd1);
        tick();
        check("start_pulse", 32'(eng_start), 32'd0);
        repeat (lat - 1) tick();
        eng_done  = 1'b1;
        eng_nack  = nack;
        eng_rdata = rd;
        tick();
        eng_done  = 1'b0;
        eng_nack  = 1'b0;
        eng_rdata = 8'h00;
    endtask

    task automatic wait_rsp(input int idx);
        int n = 0;
        while (rsp_valid === '0 && n < 100) begin tick(); n++; end
        check("rsp_valid", 32'(rsp_valid), 32'(1) << idx);
        req[idx] = 1'b0;
    endtask

    // Scoreboard: pop one expectation per response pulse
    always @(negedge clk) begin : scoreboard
        logic [W-1:0] e;
        if (eng_abort === 1'b1) abort_cnt++;
        if (resetn === 1'b1 && rsp_valid !== '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", {20'h0, enc(rsp_valid), rsp_err, rsp_rdata}, {20'h0, e});
            end
        end
    end

    initial begin
        int n;
        resetn = 1'b0; req = '0; req_rw = '0; req_reg = '0; req_wdata = '0; req_lock = '0;
        eng_done = 1'b0; eng_nack = 1'b0; eng_rdata = 8'h00;
        repeat (3) tick();
        check("reset_outs", {rsp_valid, rsp_rdata, rsp_err, eng_start, eng_abort, eng_rw,
                             eng_reg, eng_wdata, busy, grant_idx}, 32'd0);
        resetn = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Single write: requester 0, engine returns junk rdata which must be masked
        raise(0, 1'b0, 8'h98, 8'h03, 1'b0);
        push_exp(0, 1'b0, 8'h00);
        n = 0;
        while (eng_start !== 1'b1 && n < 50) begin tick(); n++; end
        check("start_latency", n, 2);
        check("eng_rw_write", 32'(eng_rw), 32'd0);
        serve(0, 8'h98, 8'h03, 10, 1'b0, 8'hEE);
        wait_rsp(0);

        // Stray eng_done while idle must not start anything
        repeat (2) tick();
        eng_done = 1'b1; eng_nack = 1'b1;
        tick();
        eng_done = 1'b0; eng_nack = 1'b0;
        tick();
        check("stray_done_busy", 32'(busy), 32'd0);

        // Round robin: last winner was 0, so order is 1,0,1,0
        raise(0, 1'b0, 8'h10, 8'hA0, 1'b0);
        raise(1, 1'b1, 8'h20, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            int w;
            w = (k % 2 == 0) ? 1 : 0;
            push_exp(w, 1'b0, (w == 1) ? 8'(8'h50 + k) : 8'h00);
            serve(w, (w == 1) ? 8'h20 : 8'h10, (w == 1) ? 8'h00 : 8'hA0, 4, 1'b0, 8'(8'h50 + k));
            wait_rsp(w);
            tick();
            if (k < 2) begin
                if (w == 1) raise(1, 1'b1, 8'h20, 8'h00, 1'b0);
                else        raise(0, 1'b0, 8'h10, 8'hA0, 1'b0);
            end
        end

        // Locked RMW: req1 keeps the engine across a gap while req0 waits
        raise(0, 1'b0, 8'h30, 8'h11, 1'b0);
        raise(1, 1'b1, 8'h16, 8'h00, 1'b1);
        push_exp(1, 1'b0, 8'h5A);
        serve(1, 8'h16, 8'h00, 6, 1'b0, 8'h5A);
        wait_rsp(1);
        repeat (3) tick();
        raise(1, 1'b0, 8'h16, 8'h5B, 1'b0);
        push_exp(1, 1'b0, 8'h00);
        serve(1, 8'h16, 8'h5B, 5, 1'b0, 8'h00);
        wait_rsp(1);
        push_exp(0, 1'b0, 8'h00);
        serve(0, 8'h30, 8'h11, 3, 1'b0, 8'h00);
        wait_rsp(0);
        repeat (2) tick();

        // Lock watchdog: owner 1 goes quiet, req0 gets in after the lock expires
        raise(1, 1'b1, 8'h16, 8'h00, 1'b1);
        push_exp(1, 1'b0, 8'h77);
        serve(1, 8'h16, 8'h00, 4, 1'b0, 8'h77);
        wait_rsp(1);
        raise(0, 1'b0, 8'h44, 8'h22, 1'b0);
        push_exp(0, 1'b0, 8'h00);
        n = 0;
        while (eng_start !== 1'b1 && n < 200) begin tick(); n++; end
        check("lock_wd_cycles", n, 1 + LOCK_TIMEOUT + 2);
        serve(0, 8'h44, 8'h22, 3, 1'b0, 8'h00);
        wait_rsp(0);
        repeat (2) tick();

        // Timeout with lock requested: abort, error response, lock released
        raise(0, 1'b0, 8'h55, 8'h99, 1'b1);
        push_exp(0, 1'b1, 8'h00);
        n = 0;
        while (eng_start !== 1'b1 && n < 200) begin tick(); n++; end
        check("to_start_seen", 32'(eng_start), 32'd1);
        n = 0;
        while (eng_abort !== 1'b1 && n < TIMEOUT + 50) begin tick(); n++; end
        check("abort_cycles", n, TIMEOUT);
        tick();
        check("abort_pulse", 32'(eng_abort), 32'd0);
        wait_rsp(0);
        raise(1, 1'b1, 8'h42, 8'h00, 1'b0);
        push_exp(1, 1'b1, 8'h40);
        n = 0;
        while (eng_start !== 1'b1 && n < 200) begin tick(); n++; end
        check("unlock_after_err", n, 3);
        check("eng_rw_read", 32'(eng_rw), 32'd1);
        serve(1, 8'h42, 8'h00, 5, 1'b1, 8'h40);
        wait_rsp(1);
        repeat (2) tick();

        // Reset in the middle of WAIT
        raise(1, 1'b1, 8'h60, 8'h00, 1'b0);
        n = 0;
        while (eng_start !== 1'b1 && n < 200) begin tick(); n++; end
        check("pre_reset_grant", 32'(grant_idx), 32'd1);
        repeat (3) tick();
        resetn = 1'b0;
        req = '0;
        #1;
        check("async_reset_outs", {rsp_valid, rsp_rdata, rsp_err, eng_start, eng_abort, eng_rw,
                                   eng_reg, eng_wdata, busy, grant_idx}, 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        raise(0, 1'b0, 8'h70, 8'h01, 1'b0);
        raise(1, 1'b1, 8'h71, 8'h00, 1'b0);
        push_exp(0, 1'b0, 8'h00);
        serve(0, 8'h70, 8'h01, 3, 1'b0, 8'h00);
        wait_rsp(0);
        push_exp(1, 1'b0, 8'h33);
        serve(1, 8'h71, 8'h00, 3, 1'b0, 8'h33);
        wait_rsp(1);

        repeat (5) tick();
        check("abort_count", abort_cnt, 1);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
